robs_control: RTL and testbench
===============================

# robs_control

Moore-style control unit for the signed Robertson's multiplier. It sequences the multiplier datapath by driving its 15-bit control word `c` and consuming the datapath status flags `zr` and `zq`. It sits directly upstream of the datapath and accepts a one-cycle `start` request from the top level. It reports `busy`, a one-cycle `done` pulse when `product` is valid in the datapath, and a sticky `err` if the datapath iteration counter disagrees with its own.

## Interface
- `WIDTH`, 8, operand width and number of iterations. Only 8 is supported, because the `zq` check is modulo 8.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  request; sampled only in IDLE
- `zr`  in  1  1 when the current multiplier LSB (`r[0]`) is 0
- `zq`  in  1  1 when the datapath down-counter value is divisible by 8
- `c`  out  15  datapath control word, decoded from state only
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse in DONE
- `err`  out  1  sticky `zq` mismatch flag; cleared by reset or an accepted `start`

## Operation
- Control bit map:
  - c[0]: load Y (multiplicand).
  - c[1]: load the down-counter with 8.
  - c[2]: clear A.
  - c[3]: load X.
  - c[5:4]: RH mux select. 00 selects A, 01 selects the shifted high half, 10 selects the ALU output.
  - c[6]: RL mux select. 0 selects X, 1 selects the shifted low half.
  - c[7]: X mux select. 0 selects the multiplier, 1 selects R low.
  - c[8]/c[9]: load RH / load RL.
  - c[10]: ALU operation. 1 adds, 0 subtracts.
  - c[11]: shift-register capture.
  - c[12]: arithmetic fill, i.e. replicate the MSB.
  - c[13]: decrement the counter.
  - c[14]: load A from R high.
- Internal `bits_left`: 4 bits, loaded with 8 in INIT and decremented in SHWB.
- States and asserted bits (every bit not listed is 0):
  - IDLE: c = 0. If `start` is high, go to INIT and clear `err`.
  - INIT: c[0], c[1], c[2], c[3] with c[7]=0. Load `bits_left` = 8. Go to LOADR.
  - LOADR: c[8], c[9] with c[5:4]=00, c[6]=0. Go to TEST.
  - TEST: c = 0.
    - If `bits_left` == 0: go to STORE. If `zq` is 0 in this cycle, set `err`.
    - Else if `zr` = 1: go to SHIFT.
    - Else: go to ADDSUB.
    - `zq` is ignored while `bits_left` != 0.
  - ADDSUB: c[10]=1, except c[10]=0 when `bits_left` == 1 (sign-bit subtract). Go to ADDWB.
  - ADDWB: hold the same c[10] value, plus c[8] with c[5:4]=10. This covers the ALU's one-cycle registered latency. Go to SHIFT.
  - SHIFT: c[11], c[12]. Go to SHWB.
  - SHWB: c[8], c[9], c[13] with c[5:4]=01, c[6]=1. Decrement `bits_left`. Go to TEST.
  - STORE: c[14], c[3] with c[7]=1. Go to DONE.
  - DONE: `done`=1, c = 0. Go to IDLE.
- `start` outside IDLE is ignored. It is neither queued nor able to restart a running operation.
- A `start` held high across DONE→IDLE begins a new operation on the next edge. This is legal back-to-back operation.

## Timing
- Reset (asynchronous, active-low): state=IDLE, `bits_left`=0, `err`=0. Therefore c=0, `busy`=0, `done`=0 immediately, with no clock needed. Applies mid-operation too; the datapath contents are then don't-care.
- `c`, `busy` and `done` depend on state only and are stable for the whole cycle. `zr` and `zq` affect only next-state and `err`.
- Each iteration takes 3 cycles if the bit is 0 (TEST, SHIFT, SHWB) and 5 cycles if the bit is 1 (adds ADDSUB, ADDWB).
- Latency: `done` goes high 27 + 2·popcount(multiplier) rising edges after the edge that samples `start`. Range is 27 to 43.
- `product` is valid from the DONE cycle until the next accepted `start`.

## Test plan
- Reset with `start`=0, then release: c=0, `busy`=0, `done`=0, `err`=0 held for 10 cycles. Assert reset asynchronously mid-cycle: outputs return to 0 with no clock edge.
- multiplicand=5, multiplier=3, with `zq` modelled correctly: `done` after 31 edges, no ADDSUB in the final iteration, datapath product=15, `err`=0.
- multiplicand=7, multiplier=0xFF (-1): `done` after 43 edges. The last ADDSUB/ADDWB pair has c[10]=0, all earlier pairs have c[10]=1, and product=0xFFF9 (-7).
- multiplier=0: `done` after 27 edges and ADDSUB is never entered. Then pulse `start` at cycle 5 of a second run: the run is not disturbed and `done` occurs exactly once.
- Force `zq`=0 in the terminating TEST cycle: `err`=1 from the next edge, still set after IDLE. The next accepted `start` clears it.
- Assert reset while in ADDWB (multiplier 0x01): next state IDLE, c=0. A subsequent `start` completes normally in 29 edges.

Source files
------------

// File: rtl/robs_control.sv
// robs_control: Moore sequencer for the signed Robertson multiplier datapath
// ports: clk; reset (async, active-low); start request; zr/zq datapath status;
//        c 15-bit control word, busy, one-cycle done, sticky err (zq disagreement)
module robs_control #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        zr,
  input  logic        zq,
  output logic [14:0] c,
  output logic        busy,
  output logic        done,
  output logic        err
);
  typedef enum logic [3:0] {IDLE, INIT, LOADR, TEST, ADDSUB, ADDWB, SHIFT, SHWB, STORE, DONE} state_t;
  state_t state, nxt;
  logic [3:0] bits_left, nbl;
  // {done, busy, c} for a state; the last iteration (bits_left == 1) subtracts the sign bit
  function automatic logic [16:0] ctl(input state_t s, input logic [3:0] bl);
    logic add;
    add = bl != 4'd1;
    ctl = '0;
    case (s)
      INIT:    ctl = {2'b01, 15'h000f};
      LOADR:   ctl = {2'b01, 15'h0300};
      TEST:    ctl = {2'b01, 15'h0000};
      ADDSUB:  ctl = {2'b01, 4'b0, add, 10'h000};
      ADDWB:   ctl = {2'b01, 4'b0, add, 10'h120};
      SHIFT:   ctl = {2'b01, 15'h1800};
      SHWB:    ctl = {2'b01, 15'h2350};
      STORE:   ctl = {2'b01, 15'h4088};
      DONE:    ctl = {2'b10, 15'h0000};
      default: ctl = '0;
    endcase
  endfunction
  always_comb begin
    nxt = state;
    nbl = bits_left;
    case (state)
      IDLE:    nxt = start ? INIT : IDLE;
      INIT:    begin nxt = LOADR; nbl = 4'(WIDTH); end
      LOADR:   nxt = TEST;
      TEST:    nxt = bits_left == 4'd0 ? STORE : zr ? SHIFT : ADDSUB;
      ADDSUB:  nxt = ADDWB;
      ADDWB:   nxt = SHIFT;
      SHIFT:   nxt = SHWB;
      SHWB:    begin nxt = TEST; nbl = bits_left - 4'd1; end
      STORE:   nxt = DONE;
      default: nxt = IDLE;
    endcase
  end
  // outputs are registered from the next state so they are a pure function of state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bits_left <= '0;
      err       <= 1'b0;
      {done, busy, c} <= '0;
    end else begin
      state     <= nxt;
      bits_left <= nbl;
      {done, busy, c} <= ctl(nxt, nbl);
      if (state == IDLE && start) err <= 1'b0;
      else if (state == TEST && bits_left == 4'd0 && !zq) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_robs_control.sv
// tb_robs_control: directed bench with a behavioural Robertson datapath driven by c
module tb_robs_control;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, zr, zq, busy, done, err;
  logic [14:0] c;
  logic [7:0] y_in = 8'd0, m_in = 8'd0, y, a, x, rh, rl, alu;
  logic [15:0] sh;
  logic [3:0] cnt;
  logic zq_ovr = 1'b0, last_c10 = 1'b0;
  int n_cmp = 0, n_bad = 0;
  int addwb_n = 0, add_n = 0, done_n = 0;
  int bw, ba, bd, e;
  always #5 clk = ~clk;
  robs_control #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .zr(zr), .zq(zq),
    .c(c), .busy(busy), .done(done), .err(err)
  );
  assign zr = ~rl[0];
  assign zq = zq_ovr ? 1'b0 : (cnt[2:0] == 3'd0);
  always @(posedge clk) begin
    if (c[0]) y <= y_in;
    if (c[1]) cnt <= 4'd8;
    else if (c[13]) cnt <= cnt - 4'd1;
    if (c[2]) a <= 8'd0;
    else if (c[14]) a <= rh;
    if (c[3]) x <= c[7] ? rl : m_in;
    alu <= c[10] ? rh + y : rh - y;
    if (c[8]) rh <= c[5:4] == 2'b10 ? alu : c[5:4] == 2'b01 ? sh[15:8] : a;
    if (c[9]) rl <= c[6] ? sh[7:0] : x;
    if (c[11]) sh <= {c[12] ? rh[7] : 1'b0, rh, rl[7:1]};
  end
  always @(negedge clk) begin
    if (c[5:4] == 2'b10) begin
      addwb_n++;
      last_c10 = c[10];
      if (c[10]) add_n++;
    end
    if (done) done_n++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // counts edges after the start-sampling edge up to, not including, the edge that raises done
  task automatic run(input logic [7:0] yy, input logic [7:0] mm, input int poke, output int edges);
    @(posedge clk); #1;
    bw = addwb_n; ba = add_n; bd = done_n;
    y_in = yy; m_in = mm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("err_clear_on_start", {31'd0, err}, 32'd0);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    edges = 0;
    while (edges < 100) begin
      @(posedge clk); #1;
      start = (poke > 0 && edges + 1 == poke);
      if (done) break;
      edges++;
    end
    start = 1'b0;
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask
  initial begin
    #1;
    chk("rst_c", {17'd0, c}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    @(posedge clk); @(posedge clk); #4;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("idle_hold", {14'd0, done, busy, err, c}, 32'd0);
    end
    run(8'd5, 8'd3, 0, e);
    chk("lat_5x3", e, 31);
    chk("prod_5x3", {16'd0, a, x}, 32'h000f);
    chk("err_5x3", {31'd0, err}, 32'd0);
    chk("addwb_5x3", addwb_n - bw, 2);
    run(8'd7, 8'hff, 0, e);
    chk("lat_7xm1", e, 43);
    chk("prod_7xm1", {16'd0, a, x}, 32'h0000fff9);
    chk("addwb_7xm1", addwb_n - bw, 8);
    chk("add_pairs_7xm1", add_n - ba, 7);
    chk("last_sub_7xm1", {31'd0, last_c10}, 32'd0);
    run(8'd5, 8'd0, 0, e);
    chk("lat_x0", e, 27);
    chk("addwb_x0", addwb_n - bw, 0);
    chk("prod_x0", {16'd0, a, x}, 32'd0);
    run(8'd5, 8'd0, 5, e);
    chk("lat_poke", e, 27);
    repeat (5) @(posedge clk);
    #1;
    chk("done_once_poke", done_n - bd, 1);
    chk("idle_after_poke", {31'd0, busy}, 32'd0);
    zq_ovr = 1'b1;
    run(8'd5, 8'd3, 0, e);
    chk("err_set", {31'd0, err}, 32'd1);
    zq_ovr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky_idle", {31'd0, err}, 32'd1);
    chk("err_idle_busy", {31'd0, busy}, 32'd0);
    run(8'd5, 8'd3, 0, e);
    chk("err_cleared_run", {31'd0, err}, 32'd0);
    chk("prod_after_err", {16'd0, a, x}, 32'h000f);
    @(posedge clk); #1;
    y_in = 8'd5; m_in = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("mid_busy_before", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_c", {17'd0, c}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_done", {31'd0, done}, 32'd0);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("after_async_idle", {31'd0, busy}, 32'd0);
    y_in = 8'd9; m_in = 8'h01; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e = 0;
    while (c[5:4] != 2'b10 && e < 60) begin
      @(posedge clk); #1;
      e++;
    end
    chk("reached_addwb", {30'd0, c[5:4]}, 32'd2);
    #2 reset = 1'b0;
    #1;
    chk("addwb_rst_c", {17'd0, c}, 32'd0);
    chk("addwb_rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("addwb_rst_hold", {17'd0, c}, 32'd0);
    #3 reset = 1'b1;
    run(8'd9, 8'h01, 0, e);
    chk("lat_x1", e, 29);
    chk("prod_9x1", {16'd0, a, x}, 32'h0009);
    chk("err_x1", {31'd0, err}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
